// File: rtl/espnet_addr_pkg.sv
// Shared constants, FSM state encoding and lane-validity test for the address serializer.
// An address field whose MSB is set marks its lane as invalid.
package espnet_addr_pkg;

  localparam int ADDR_LANES = 256;
  localparam int ADDR_ROW_W = 10;
  localparam int ADDR_COL_W = 11;
  localparam int ADDR_CH_W  = 8;
  localparam int ADDR_IDX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2
  } ser_state_t;

  function automatic logic lane_is_valid(input logic row_msb, input logic col_msb,
                                         input logic ch_msb);
    return !(row_msb || col_msb || ch_msb);
  endfunction

endpackage

// File: rtl/address_serializer_lane_mux.sv
// Purpose: combinational LANES-to-1 select of row/col/ch by lane index, plus lane-valid flag.
// Latency: zero cycles. Backpressure: none, pure combinational.
module addr_lane_mux
  import espnet_addr_pkg::*;
#(
  parameter int LANES = ADDR_LANES,
  parameter int ROW_W = ADDR_ROW_W,
  parameter int COL_W = ADDR_COL_W,
  parameter int CH_W  = ADDR_CH_W,
  parameter int IDX_W = ADDR_IDX_W
) (
  input  logic [ROW_W*LANES-1:0] i_row_vec,
  input  logic [COL_W*LANES-1:0] i_col_vec,
  input  logic [CH_W*LANES-1:0]  i_ch_vec,
  input  logic [IDX_W-1:0]       i_idx,
  output logic [ROW_W-1:0]       o_row,
  output logic [COL_W-1:0]       o_col,
  output logic [CH_W-1:0]        o_ch,
  output logic                   o_lane_vld
);

  always_comb begin
    o_row = '0;
    o_col = '0;
    o_ch  = '0;
    for (int k = 0; k < LANES; k++) begin
      if (i_idx == IDX_W'(k)) begin
        o_row = i_row_vec[k*ROW_W +: ROW_W];
        o_col = i_col_vec[k*COL_W +: COL_W];
        o_ch  = i_ch_vec[k*CH_W +: CH_W];
      end
    end
  end

  assign o_lane_vld = lane_is_valid(o_row[ROW_W-1], o_col[COL_W-1], o_ch[CH_W-1]);

endmodule

// File: rtl/address_serializer.sv
// Purpose: serializes one captured batch of row/col/ch addresses, lane 0 first, skipping invalid lanes.
// Latency: 2 cycles accept-to-first-out; 2 cycles per valid lane, 1 per invalid. Optional ADDR_SER_STATS_EN adds emit/skip counters.
// Backpressure: in_ready only in IDLE; an emitted address is held stable until out_ready.
module address_serializer
  import espnet_addr_pkg::*;
#(
  parameter int LANES = ADDR_LANES,
  parameter int ROW_W = ADDR_ROW_W,
  parameter int COL_W = ADDR_COL_W,
  parameter int CH_W  = ADDR_CH_W,
  parameter int IDX_W = ADDR_IDX_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ROW_W*LANES-1:0] row_in,
  input  logic [COL_W*LANES-1:0] col_in,
  input  logic [CH_W*LANES-1:0]  ch_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ROW_W-1:0]       row_out,
  output logic [COL_W-1:0]       col_out,
  output logic [CH_W-1:0]        ch_out,
  output logic [IDX_W-1:0]       lane_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   batch_done
`ifdef ADDR_SER_STATS_EN
  ,output logic [IDX_W:0]        emit_count
  ,output logic [IDX_W:0]        skip_count
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
  localparam logic [ROW_W-1:0] ROW_INV  = {1'b1, {(ROW_W-1){1'b0}}};
  localparam logic [COL_W-1:0] COL_INV  = {1'b1, {(COL_W-1){1'b0}}};
  localparam logic [CH_W-1:0]  CH_INV   = {1'b1, {(CH_W-1){1'b0}}};

  ser_state_t             r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [ROW_W*LANES-1:0] r_row_cap;
  logic [COL_W*LANES-1:0] r_col_cap;
  logic [CH_W*LANES-1:0]  r_ch_cap;
  logic [ROW_W-1:0]       r_row_out;
  logic [COL_W-1:0]       r_col_out;
  logic [CH_W-1:0]        r_ch_out;
  logic [IDX_W-1:0]       r_lane_out;
  logic                   r_out_valid;
  logic                   r_batch_done;

  logic [ROW_W-1:0]       w_row;
  logic [COL_W-1:0]       w_col;
  logic [CH_W-1:0]        w_ch;
  logic                   w_lane_vld;
  logic                   w_last;

  addr_lane_mux #(
    .LANES (LANES),
    .ROW_W (ROW_W),
    .COL_W (COL_W),
    .CH_W  (CH_W),
    .IDX_W (IDX_W)
  ) u_lane_mux (
    .i_row_vec  (r_row_cap),
    .i_col_vec  (r_col_cap),
    .i_ch_vec   (r_ch_cap),
    .i_idx      (r_idx),
    .o_row      (w_row),
    .o_col      (w_col),
    .o_ch       (w_ch),
    .o_lane_vld (w_lane_vld)
  );

  assign w_last = (r_idx == LAST_IDX);

`ifdef ADDR_SER_STATS_EN
  logic [IDX_W:0] r_emit_count;
  logic [IDX_W:0] r_skip_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_emit_count <= '0;
      r_skip_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_emit_count <= '0;
          r_skip_count <= '0;
        end
        ST_SCAN: if (!w_lane_vld) r_skip_count <= r_skip_count + 1'b1;
        ST_EMIT: if (r_out_valid && out_ready) r_emit_count <= r_emit_count + 1'b1;
        default: ;
      endcase
    end
  end

  assign emit_count = r_emit_count;
  assign skip_count = r_skip_count;
`endif

  // Batch capture is a plain enable register; a reset simply abandons whatever it holds.
  always_ff @(posedge clock) begin
    if (r_state == ST_IDLE && in_valid) begin
      r_row_cap <= row_in;
      r_col_cap <= col_in;
      r_ch_cap  <= ch_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_row_out    <= ROW_INV;
      r_col_out    <= COL_INV;
      r_ch_out     <= CH_INV;
      r_lane_out   <= '0;
      r_out_valid  <= 1'b0;
      r_batch_done <= 1'b0;
    end else begin
      r_batch_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_idx   <= '0;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_lane_vld) begin
            r_row_out   <= w_row;
            r_col_out   <= w_col;
            r_ch_out    <= w_ch;
            r_lane_out  <= r_idx;
            r_out_valid <= 1'b1;
            r_state     <= ST_EMIT;
          end else if (w_last) begin
            r_batch_done <= 1'b1;
            r_state      <= ST_IDLE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_EMIT: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            if (w_last) begin
              r_batch_done <= 1'b1;
              r_state      <= ST_IDLE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_SCAN;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign row_out    = r_row_out;
  assign col_out    = r_col_out;
  assign ch_out     = r_ch_out;
  assign lane_out   = r_lane_out;
  assign out_valid  = r_out_valid;
  assign batch_done = r_batch_done;

endmodule

// File: tb/tb_address_serializer.sv
// Bench for address_serializer at LANES=4: randomized batches against a queue-based reference model.
// Build with ADDR_SER_STATS_EN defined to also cover the emit/skip counters.
module tb_address_serializer;

  localparam int LANES = 4;
  localparam int ROW_W = 10;
  localparam int COL_W = 11;
  localparam int CH_W  = 8;
  localparam int IDX_W = 8;

  localparam logic [ROW_W-1:0] RST_ROW = 10'h200;
  localparam logic [COL_W-1:0] RST_COL = 11'h400;
  localparam logic [CH_W-1:0]  RST_CH  = 8'h80;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [ROW_W*LANES-1:0] row_in;
  logic [COL_W*LANES-1:0] col_in;
  logic [CH_W*LANES-1:0]  ch_in;
  logic                   in_valid;
  logic                   in_ready;
  logic [ROW_W-1:0]       row_out;
  logic [COL_W-1:0]       col_out;
  logic [CH_W-1:0]        ch_out;
  logic [IDX_W-1:0]       lane_out;
  logic                   out_valid;
  logic                   out_ready;
  logic                   batch_done;
`ifdef ADDR_SER_STATS_EN
  logic [IDX_W:0]         emit_count;
  logic [IDX_W:0]         skip_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [ROW_W-1:0] b_row [LANES];
  logic [COL_W-1:0] b_col [LANES];
  logic [CH_W-1:0]  b_ch  [LANES];

  address_serializer #(
    .LANES (LANES),
    .ROW_W (ROW_W),
    .COL_W (COL_W),
    .CH_W  (CH_W),
    .IDX_W (IDX_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .row_in     (row_in),
    .col_in     (col_in),
    .ch_in      (ch_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .row_out    (row_out),
    .col_out    (col_out),
    .ch_out     (ch_out),
    .lane_out   (lane_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .batch_done (batch_done)
`ifdef ADDR_SER_STATS_EN
    ,.emit_count (emit_count)
    ,.skip_count (skip_count)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Each field of each lane gets its MSB set with probability p_inv percent.
  task automatic fill_random(input int p_inv);
    for (int k = 0; k < LANES; k++) begin
      b_row[k] = ROW_W'($urandom);
      b_col[k] = COL_W'($urandom);
      b_ch[k]  = CH_W'($urandom);
      b_row[k][ROW_W-1] = ($urandom_range(0, 99) < p_inv);
      b_col[k][COL_W-1] = ($urandom_range(0, 99) < p_inv);
      b_ch[k][CH_W-1]   = ($urandom_range(0, 99) < p_inv);
    end
  endtask

  task automatic pack_batch();
    for (int k = 0; k < LANES; k++) begin
      row_in[k*ROW_W +: ROW_W] = b_row[k];
      col_in[k*COL_W +: COL_W] = b_col[k];
      ch_in[k*CH_W +: CH_W]    = b_ch[k];
    end
  endtask

  task automatic scramble_inputs();
    for (int k = 0; k < LANES; k++) begin
      row_in[k*ROW_W +: ROW_W] = ROW_W'($urandom);
      col_in[k*COL_W +: COL_W] = COL_W'($urandom);
      ch_in[k*CH_W +: CH_W]    = CH_W'($urandom);
    end
  endtask

  // rdy_mode 0: always ready; 1: random ready; 2: hold ready low for the first stall_n valid cycles.
  // Returns on the negedge of the batch_done cycle so a following call can start back-to-back.
  task automatic run_batch(input int rdy_mode, input int stall_n, input string tag);
    int exp_q[$];
    int n_inv = 0, n_vld, first_exp, first_obs = -1;
    int busy = 0, stalls = 0, cyc, stall_left = stall_n;
    bit done = 0, hold = 0, rdy;
    logic [ROW_W-1:0] h_row;
    logic [COL_W-1:0] h_col;
    logic [CH_W-1:0]  h_ch;
    logic [IDX_W-1:0] h_lane;
    int lane;

    for (int k = 0; k < LANES; k++) begin
      if (!b_row[k][ROW_W-1] && !b_col[k][COL_W-1] && !b_ch[k][CH_W-1]) exp_q.push_back(k);
      else n_inv++;
    end
    n_vld     = exp_q.size();
    first_exp = (n_vld > 0) ? 2 + exp_q[0] : -1;

    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL %s in_ready_timeout: in_ready=%b required 1", tag, in_ready);
      return;
    end

    pack_batch();
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    scramble_inputs();

    cyc = 1;
    while (!done && cyc <= 300) begin
      if (cyc == 1) begin
        checks++;
        if (in_ready !== 1'b0 || batch_done !== 1'b0) begin
          errors++;
          $display("FAIL %s accept: in_ready=%b batch_done=%b required 0 0", tag, in_ready, batch_done);
        end
`ifdef ADDR_SER_STATS_EN
        checks++;
        if (emit_count !== '0 || skip_count !== '0) begin
          errors++;
          $display("FAIL %s stats_clear: emit=%0d skip=%0d required 0 0", tag, emit_count, skip_count);
        end
`endif
      end
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || row_out !== h_row || col_out !== h_col ||
            ch_out !== h_ch || lane_out !== h_lane) begin
          errors++;
          $display("FAIL %s hold: vld=%b row=%h col=%h ch=%h lane=%0d required 1 %h %h %h %0d",
                   tag, out_valid, row_out, col_out, ch_out, lane_out, h_row, h_col, h_ch, h_lane);
        end
      end
      if (!in_ready) busy++;
      if (batch_done === 1'b1) begin
        done = 1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s done_state: in_ready=%b out_valid=%b required 1 0", tag, in_ready, out_valid);
        end
`ifdef ADDR_SER_STATS_EN
        checks++;
        if (emit_count !== (IDX_W+1)'(n_vld) || skip_count !== (IDX_W+1)'(n_inv)) begin
          errors++;
          $display("FAIL %s stats: emit=%0d skip=%0d required %0d %0d",
                   tag, emit_count, skip_count, n_vld, n_inv);
        end
`endif
      end else begin
        if (out_valid === 1'b1) begin
          if (first_obs < 0) first_obs = cyc;
          case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            default: rdy = (stall_left == 0);
          endcase
          out_ready = rdy;
          if (!rdy) begin
            stalls++;
            if (stall_left > 0) stall_left--;
            hold   = 1;
            h_row  = row_out;
            h_col  = col_out;
            h_ch   = ch_out;
            h_lane = lane_out;
          end else begin
            hold = 0;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL %s extra_output: lane=%0d row=%h required no output", tag, lane_out, row_out);
            end else begin
              lane = exp_q.pop_front();
              if (lane_out !== IDX_W'(lane) || row_out !== b_row[lane] ||
                  col_out !== b_col[lane] || ch_out !== b_ch[lane]) begin
                errors++;
                $display("FAIL %s data: lane=%0d row=%h col=%h ch=%h required %0d %h %h %h",
                         tag, lane_out, row_out, col_out, ch_out,
                         lane, b_row[lane], b_col[lane], b_ch[lane]);
              end
            end
          end
        end else begin
          hold = 0;
          out_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clock);
        cyc++;
      end
    end
    out_ready = 1'b0;

    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s done_timeout: batch_done not seen in %0d cycles, required within bound", tag, cyc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing: %0d lanes not emitted, required 0", tag, exp_q.size());
    end
    checks++;
    if (first_obs != first_exp) begin
      errors++;
      $display("FAIL %s first_valid: cycle %0d required %0d", tag, first_obs, first_exp);
    end
    checks++;
    if (busy != n_inv + 2*n_vld + stalls) begin
      errors++;
      $display("FAIL %s busy_cycles: %0d required %0d", tag, busy, n_inv + 2*n_vld + stalls);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      checks++;
      if (batch_done !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s idle: batch_done=%b out_valid=%b in_ready=%b required 0 0 1",
                 tag, batch_done, out_valid, in_ready);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (out_valid !== 1'b0 || batch_done !== 1'b0 || in_ready !== 1'b1 || lane_out !== '0 ||
        row_out !== RST_ROW || col_out !== RST_COL || ch_out !== RST_CH) begin
      errors++;
      $display("FAIL %s reset_vals: vld=%b done=%b rdy=%b lane=%0d row=%h col=%h ch=%h required 0 0 1 0 %h %h %h",
               tag, out_valid, batch_done, in_ready, lane_out, row_out, col_out, ch_out,
               RST_ROW, RST_COL, RST_CH);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    row_in = '0;
    col_in = '0;
    ch_in = '0;
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    reset = 1'b0;
    idle(2, "reset");
  endtask

  task automatic test_all_valid();
    fill_random(0);
    for (int k = 0; k < LANES; k++) b_row[k] = ROW_W'(k + 1);
    run_batch(0, 0, "all_valid");
    idle(1, "all_valid");
  endtask

  task automatic test_skip();
    fill_random(0);
    b_row[1][ROW_W-1] = 1'b1;
    b_ch[3][CH_W-1]   = 1'b1;
    run_batch(0, 0, "skip");
    idle(1, "skip");
  endtask

  task automatic test_all_invalid();
    fill_random(40);
    for (int k = 0; k < LANES; k++) b_col[k][COL_W-1] = 1'b1;
    run_batch(1, 0, "all_invalid");
    idle(1, "all_invalid");
  endtask

  task automatic test_backpressure();
    fill_random(0);
    run_batch(2, 5, "backpressure");
    idle(1, "backpressure");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      fill_random(15);
      run_batch(1, 0, "random");
      if ($urandom_range(0, 1) == 1) idle(1, "random");
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      fill_random(20);
      run_batch(0, 0, "back_to_back");
    end
    idle(1, "back_to_back");
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    fill_random(0);
    pack_batch();
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    while (!(out_valid === 1'b1 && lane_out === IDX_W'(2)) && cyc < 30) begin
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (!(out_valid === 1'b1 && lane_out === IDX_W'(2))) begin
      errors++;
      $display("FAIL reset_mid reach_lane2: vld=%b lane=%0d required 1 2", out_valid, lane_out);
    end
    reset = 1'b1;
    out_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    check_reset_vals("reset_mid");
    idle(LANES + 4, "reset_mid");
    fill_random(10);
    b_row[0][ROW_W-1] = 1'b0;
    b_col[0][COL_W-1] = 1'b0;
    b_ch[0][CH_W-1]   = 1'b0;
    run_batch(0, 0, "after_reset");
    idle(1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_all_valid();
    test_skip();
    test_all_invalid();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
